// File: rtl/ram_host_bridge.sv
// Byte-stream 'W'/'R' command bridge giving a host burst access to a synchronous single-port RAM.
// Build option: define RAM_BRIDGE_ACK_EN to return a '+' (0x2B) byte after every write burst.
module ram_host_bridge #(
  parameter int A = 10,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         ram_cs,
  output logic         ram_rw,
  output logic [A-1:0] ram_addr,
  output logic [D-1:0] ram_wdata,
  input  logic [D-1:0] ram_rdata,
  output logic         busy,
  output logic         cmd_err
);

  localparam logic [7:0]   CMD_W    = 8'h57;
  localparam logic [7:0]   CMD_R    = 8'h52;
  localparam logic [7:0]   ACK_BYTE = 8'h2B;
  localparam logic [A-1:0] ADDR_ONE = {{(A-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    S_IDLE, S_AHI, S_ALO, S_CNT, S_WDATA, S_RREQ, S_RWAIT, S_RSEND
`ifdef RAM_BRIDGE_ACK_EN
    , S_ACK
`endif
  } state_t;

  state_t       state_q, state_d;
  logic         is_rd_q, is_rd_d;
  logic [7:0]   ahi_q, ahi_d;
  logic [A-1:0] addr_q, addr_d;
  logic [8:0]   cnt_q, cnt_d;
  logic [7:0]   tx_data_q, tx_data_d;
  logic         tx_valid_q, tx_valid_d;
  logic         cs_q, cs_d;
  logic         rw_q, rw_d;
  logic [A-1:0] ram_addr_q, ram_addr_d;
  logic [D-1:0] wdata_q, wdata_d;
  logic         err_q, err_d;

  logic [15:0]  wire_addr;
  logic [A-1:0] addr_inc;
  logic         rx_fire, tx_fire, last;

  // The 16-bit wire address keeps only its low A bits (A must not exceed 16).
  assign wire_addr = {ahi_q, rx_data};
  assign addr_inc  = addr_q + ADDR_ONE;
  assign rx_fire   = rx_valid && rx_ready;
  assign tx_fire   = tx_valid_q && tx_ready;
  assign last      = (cnt_q == 9'd1);

  assign rx_ready = (state_q inside {S_IDLE, S_AHI, S_ALO, S_CNT, S_WDATA});
  assign busy     = (state_q != S_IDLE);

  always_comb begin
    state_d    = state_q;
    is_rd_d    = is_rd_q;
    ahi_d      = ahi_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    cs_d       = 1'b0;
    rw_d       = 1'b1;
    ram_addr_d = ram_addr_q;
    wdata_d    = wdata_q;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: if (rx_fire) begin
        if (rx_data == CMD_W || rx_data == CMD_R) begin
          is_rd_d = (rx_data == CMD_R);
          state_d = S_AHI;
        end else begin
          err_d = 1'b1;
        end
      end
      S_AHI: if (rx_fire) begin
        ahi_d   = rx_data;
        state_d = S_ALO;
      end
      S_ALO: if (rx_fire) begin
        addr_d  = wire_addr[A-1:0];
        state_d = S_CNT;
      end
      S_CNT: if (rx_fire) begin
        cnt_d = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
        // The read strobe is registered here so that it is visible while in RREQ.
        if (is_rd_q) begin
          state_d    = S_RREQ;
          cs_d       = 1'b1;
          ram_addr_d = addr_q;
        end else begin
          state_d = S_WDATA;
        end
      end
      S_WDATA: if (rx_fire) begin
        cs_d       = 1'b1;
        rw_d       = 1'b0;
        ram_addr_d = addr_q;
        wdata_d    = rx_data;
        addr_d     = addr_inc;
        cnt_d      = cnt_q - 9'd1;
`ifdef RAM_BRIDGE_ACK_EN
        if (last) state_d = S_ACK;
`else
        if (last) state_d = S_IDLE;
`endif
      end
      S_RREQ:  state_d = S_RWAIT;
      S_RWAIT: begin
        tx_data_d  = ram_rdata;
        tx_valid_d = 1'b1;
        state_d    = S_RSEND;
      end
      S_RSEND: if (tx_fire) begin
        tx_valid_d = 1'b0;
        addr_d     = addr_inc;
        cnt_d      = cnt_q - 9'd1;
        if (last) begin
          state_d = S_IDLE;
        end else begin
          state_d    = S_RREQ;
          cs_d       = 1'b1;
          ram_addr_d = addr_inc;
        end
      end
`ifdef RAM_BRIDGE_ACK_EN
      S_ACK: begin
        if (!tx_valid_q) begin
          tx_data_d  = ACK_BYTE;
          tx_valid_d = 1'b1;
        end else if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      is_rd_q    <= 1'b0;
      ahi_q      <= 8'h00;
      addr_q     <= '0;
      cnt_q      <= 9'd0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      cs_q       <= 1'b0;
      rw_q       <= 1'b1;
      ram_addr_q <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_rd_q    <= is_rd_d;
      ahi_q      <= ahi_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      cs_q       <= cs_d;
      rw_q       <= rw_d;
      ram_addr_q <= ram_addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign ram_cs    = cs_q;
  assign ram_rw    = rw_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = wdata_q;
  assign cmd_err   = err_q;

endmodule

// File: tb/tb_ram_host_bridge.sv
// Scoreboard bench for ram_host_bridge: drivers push expected RAM strobes, tx bytes and
// cmd_err pulses into queues; a negedge monitor pops and compares them as the DUT emits them.
`timescale 1ns/1ps
module tb_ram_host_bridge;
  localparam int A    = 10;
  localparam int SIZE = 1 << A;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic         rx_ready;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b0;
  logic         ram_cs, ram_rw;
  logic [A-1:0] ram_addr;
  logic [7:0]   ram_wdata;
  logic [7:0]   ram_rdata = 8'h00;
  logic         busy, cmd_err;

  ram_host_bridge #(.A(A), .D(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ram_cs(ram_cs), .ram_rw(ram_rw), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  // Attached synchronous RAM with registered read.
  logic [7:0] ram_mem [SIZE];
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_rw) ram_rdata <= ram_mem[ram_addr];
      else        ram_mem[ram_addr] <= ram_wdata;
    end
  end

  // Reference model: memory image as the host protocol says it should look.
  int ref_mem [SIZE];
  int wbuf [256];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int addr; int data; int cyc; } wexp_t;
  wexp_t exp_wr[$];
  int    exp_rd[$];
  int    exp_tx[$];
  int    exp_err[$];
  wexp_t we;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic bad(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got an unexpected or missing event, required none", name);
  endtask

  task automatic finish_tb();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  // tx_ready: random back-pressure unless a stall is being forced.
  bit force_low = 1'b0;
  always @(posedge clk) begin
    #1;
    tx_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor / scoreboard.
  bit         stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;
  always @(negedge clk) begin
    if (reset_n) begin
      if (ram_cs && !ram_rw) begin
        if (exp_wr.size() == 0) bad("wr_unexpected");
        else begin
          we = exp_wr.pop_front();
          chk("wr_addr", int'(ram_addr), we.addr);
          chk("wr_data", int'(ram_wdata), we.data);
          chk("wr_cycle", cyc, we.cyc);
        end
      end
      if (ram_cs && ram_rw) begin
        if (exp_rd.size() == 0) bad("rd_unexpected");
        else chk("rd_addr", int'(ram_addr), exp_rd.pop_front());
      end
      if (stall_prev) begin
        chk("stall_valid", int'(tx_valid), 1);
        chk("stall_data", int'(tx_data), int'(stall_data));
      end
      if (tx_valid) chk("cs_during_tx", int'(ram_cs), 0);
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) bad("tx_unexpected");
        else chk("tx_data", int'(tx_data), exp_tx.pop_front());
      end
      if (cmd_err) begin
        if (exp_err.size() == 0) bad("cmd_err_unexpected");
        else chk("cmd_err_cycle", cyc, exp_err.pop_front());
      end
      stall_prev = tx_valid && !tx_ready;
      stall_data = tx_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Present a byte from a negedge and return after the accepting posedge.
  task automatic send_byte(input logic [7:0] b, output int acc_cyc);
    int waitn;
    waitn = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready) begin
      @(negedge clk);
      waitn++;
      if (waitn > 4000) begin
        bad("rx_ready_timeout");
        finish_tb();
      end
    end
    acc_cyc = cyc + 1;
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_write(input int a16, input int n);
    int c;
    int a;
    send_byte(8'h57, c);
    send_byte(8'(a16 >> 8), c);
    send_byte(8'(a16), c);
    send_byte(8'(n % 256), c);
    for (int i = 0; i < n; i++) begin
      send_byte(8'(wbuf[i]), c);
      a = (a16 + i) % SIZE;
      ref_mem[a] = wbuf[i] & 8'hFF;
      exp_wr.push_back('{addr: a, data: wbuf[i] & 8'hFF, cyc: c});
    end
`ifdef RAM_BRIDGE_ACK_EN
    exp_tx.push_back(8'h2B);
`endif
  endtask

  task automatic do_read(input int a16, input int n);
    int c;
    int a;
    send_byte(8'h52, c);
    send_byte(8'(a16 >> 8), c);
    send_byte(8'(a16), c);
    send_byte(8'(n % 256), c);
    for (int i = 0; i < n; i++) begin
      a = (a16 + i) % SIZE;
      exp_rd.push_back(a);
      exp_tx.push_back(ref_mem[a]);
    end
  endtask

  task automatic bad_byte(input logic [7:0] b);
    int c;
    send_byte(b, c);
    exp_err.push_back(c);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    idle();
    while (exp_wr.size() != 0 || exp_rd.size() != 0 || exp_tx.size() != 0 ||
           exp_err.size() != 0 || busy) begin
      @(negedge clk);
      n++;
      if (n > 5000) begin
        bad("drain_timeout");
        finish_tb();
      end
    end
  endtask

  initial begin
    #500000;
    bad("global_timeout");
    finish_tb();
  end

  initial begin
    int c;
    int op;
    int n;
    int a16;
    int d0;
    int d1;
    int waitn;
    for (int i = 0; i < SIZE; i++) begin
      ram_mem[i] = 8'($urandom);
      ref_mem[i] = int'(ram_mem[i]);
    end

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_rx_ready", int'(rx_ready), 1);
    chk("rst_tx_valid", int'(tx_valid), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_ram_cs", int'(ram_cs), 0);
    chk("rst_ram_rw", int'(ram_rw), 1);
    chk("rst_ram_addr", int'(ram_addr), 0);
    chk("rst_ram_wdata", int'(ram_wdata), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cmd_err", int'(cmd_err), 0);
    reset_n = 1'b1;

    // Basic write then read back.
    wbuf[0] = 8'hAA; wbuf[1] = 8'hBB; wbuf[2] = 8'hCC;
    do_write(16'h0010, 3);
    do_read(16'h0010, 3);
    wait_drain();

    // Address wrap at the top of the RAM.
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    do_write(16'h03FF, 2);
    do_read(16'h03FF, 2);
    wait_drain();

    // CNT = 0 means a 256-byte burst.
    for (int i = 0; i < 256; i++) wbuf[i] = $urandom_range(0, 255);
    do_write(16'h0000, 256);
    idle();
    @(negedge clk);
`ifndef RAM_BRIDGE_ACK_EN
    chk("busy_after_burst", int'(busy), 0);
`endif
    wait_drain();

    // Forced tx stall during a 2-byte read.
    force_low = 1'b1;
    do_read(16'h0100, 2);
    idle();
    waitn = 0;
    while (!tx_valid) begin
      @(negedge clk);
      waitn++;
      if (waitn > 100) begin
        bad("tx_valid_timeout");
        finish_tb();
      end
    end
    repeat (10) @(negedge clk);
    force_low = 1'b0;
    wait_drain();

    // Unknown command byte.
    bad_byte(8'h41);
    @(negedge clk);
    rx_valid = 1'b0;
    chk("idle_after_bad", int'(busy), 0);
    wait_drain();

    // Reset after 2 of 4 write data bytes: only the first strobe may reach the RAM.
    d0 = $urandom_range(0, 255);
    d1 = $urandom_range(0, 255);
    send_byte(8'h57, c);
    send_byte(8'h00, c);
    send_byte(8'h40, c);
    send_byte(8'h04, c);
    send_byte(8'(d0), c);
    ref_mem[16'h040] = d0;
    exp_wr.push_back('{addr: 16'h040, data: d0, cyc: c});
    send_byte(8'(d1), c);
    #1 reset_n = 1'b0;
    #1;
    chk("reset_cs_drop", int'(ram_cs), 0);
    chk("reset_busy", int'(busy), 0);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    do_read(16'h0040, 2);
    wait_drain();

    // Single-byte write: no tx traffic unless the acknowledge is built in.
    wbuf[0] = 8'h5A;
    do_write(16'h0020, 1);
    wait_drain();

    // Randomized command mix.
    for (int t = 0; t < 30; t++) begin
      op  = $urandom_range(0, 9);
      n   = $urandom_range(1, 8);
      a16 = $urandom_range(0, 16'hFFFF);
      if (op == 0) begin
        c = $urandom_range(0, 255);
        if (c == 8'h57 || c == 8'h52) c = 8'h00;
        bad_byte(8'(c));
      end else if (op < 5) begin
        for (int i = 0; i < n; i++) wbuf[i] = $urandom_range(0, 255);
        do_write(a16, n);
      end else begin
        do_read(a16, n);
      end
    end
    wait_drain();

    finish_tb();
  end

endmodule
